keypad_entry_unit: RTL and testbench

Parametrised keypad entry and conversion unit; next generation of the calculator's input stage. It accepts decoded key events from the keypad scanner and builds a signed decimal operand of up to DIGITS digits, with editing keys (backspace, clear, sign toggle). On enter it serially converts BCD to a WIDTH-bit two's-complement value, with overflow saturation. It sits between the keypad scanner and the arithmetic unit, and also drives the display path.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_entry_unit_bcd_serial_to_bin.sv | 73 +++++++
 rtl/keypad_entry_unit.sv | 171 +++++++++++++++++
 tb/tb_keypad_entry_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared key codes, FSM state encoding and display constants for
//            the keypad entry unit and its BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam logic [3:0] KEY_SIGN     = 4'hA;
  localparam logic [3:0] KEY_BS       = 4'hB;
  localparam logic [3:0] KEY_CLR      = 4'hC;
  localparam logic [3:0] KEY_ENTER    = 4'hD;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/keypad_entry_unit_bcd_serial_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_to_bin
// Purpose  : Serial BCD-to-binary accumulator (acc <- acc*10 + digit) with
//            sticky overflow against the signed limit and saturated
//            two's-complement result.
// Ports    : clk_i, rst_ni      clock / async active-low reset
//            start_i            clear accumulator and overflow
//            step_i             fold digit_i into the accumulator
//            digit_i[3:0]       BCD digit
//            neg_i              selects negative limit and negates result
//            result_o[WIDTH-1:0] saturated two's-complement value
//            ovf_o              sticky overflow
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_to_bin
  import keypad_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [3:0]       digit_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);

  // Extra headroom so acc*10+9 never wraps before the limit compare.
  localparam int EW = WIDTH + 5;
  localparam logic [WIDTH-1:0] c_pos_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_neg_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [EW-1:0]    prod, limit;
  logic [WIDTH-1:0] acc_w;

  always_comb begin
    limit = neg_i ? (EW'(1) << (WIDTH-1)) : ((EW'(1) << (WIDTH-1)) - EW'(1));
    prod  = (EW'(acc_q) * EW'(10)) + EW'(digit_i);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (start_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (step_i && !ovf_q) begin
      // Once over the limit the accumulator freezes; only ovf matters.
      if (prod > limit) ovf_d = 1'b1;
      else              acc_d = prod[WIDTH:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // acc never exceeds 2^(WIDTH-1) unflagged, so the low WIDTH bits carry it.
  assign acc_w    = acc_q[WIDTH-1:0];
  assign result_o = ovf_q ? (neg_i ? c_neg_min : c_pos_max)
                          : (neg_i ? (-acc_w) : acc_w);
  assign ovf_o    = ovf_q;

endmodule
`default_nettype wire

// File: rtl/keypad_entry_unit.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_unit
// Purpose  : Builds a signed decimal operand from keypad events (digits,
//            sign toggle, backspace, clear) and on enter converts it to a
//            saturated WIDTH-bit two's-complement value, held until accepted.
// Ports    : clk_i, rst_ni            clock / async active-low reset
//            key_valid_i, key_code_i  key strobe and code
//            out_ready_i              consumer accepts result
//            bcd_disp_o               entered digits, LSD in nibble 0, 0xF blank
//            digit_count_o            digits entered
//            neg_o                    entry sign
//            busy_o                   converting or holding; keys dropped
//            out_valid_o, out_value_o, out_ovf_o   result handshake
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_unit
  import keypad_pkg::*;
#(
  parameter int DIGITS = 11,
  parameter int WIDTH  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         key_valid_i,
  input  logic [3:0]                   key_code_i,
  input  logic                         out_ready_i,
  output logic [4*DIGITS-1:0]          bcd_disp_o,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count_o,
  output logic                         neg_o,
  output logic                         busy_o,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_value_o,
  output logic                         out_ovf_o
);

  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] c_max_count = CW'(DIGITS);

  entry_state_t            state_q, state_d;
  logic [4*DIGITS-1:0]     disp_q, disp_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    neg_q, neg_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]        out_value_q, out_value_d;
  logic                    out_ovf_q, out_ovf_d;

  logic [CW-1:0]           idx_m1;
  logic [3:0]              nibble, digit;
  logic                    conv_start, conv_step, conv_ovf;
  logic [WIDTH-1:0]        conv_result;

  // Digit currently being folded in, most significant entered digit first.
  always_comb begin
    idx_m1 = idx_q - CW'(1);
    nibble = BLANK_NIBBLE;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_m1 == CW'(i)) nibble = disp_q[4*i +: 4];
    end
    // An empty entry converts its blank nibble 0 as a zero digit.
    digit = (nibble > 4'd9) ? 4'd0 : nibble;
  end

  always_comb begin
    state_d     = state_q;
    disp_d      = disp_q;
    count_d     = count_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    out_value_d = out_value_q;
    out_ovf_d   = out_ovf_q;
    conv_start  = 1'b0;
    conv_step   = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (key_valid_i) begin
          if (key_code_i <= 4'd9) begin
            if (count_q < c_max_count) begin
              disp_d  = {disp_q[4*DIGITS-5:0], key_code_i};
              count_d = count_q + CW'(1);
            end
          end else begin
            case (key_code_i)
              KEY_SIGN: neg_d = ~neg_q;
              KEY_BS: begin
                if (count_q != '0) begin
                  disp_d  = {BLANK_NIBBLE, disp_q[4*DIGITS-1:4]};
                  count_d = count_q - CW'(1);
                end
              end
              KEY_CLR: begin
                disp_d  = {DIGITS{BLANK_NIBBLE}};
                count_d = '0;
                neg_d   = 1'b0;
              end
              KEY_ENTER: begin
                // An empty entry still spends one conversion step.
                idx_d      = (count_q == '0) ? CW'(1) : count_q;
                conv_start = 1'b1;
                state_d    = ST_CONVERT;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CONVERT: begin
        if (idx_q != '0) begin
          conv_step = 1'b1;
          idx_d     = idx_m1;
        end else begin
          out_value_d = conv_result;
          out_ovf_d   = conv_ovf;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          disp_d  = {DIGITS{BLANK_NIBBLE}};
          count_d = '0;
          neg_d   = 1'b0;
          state_d = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ENTRY;
      disp_q      <= {DIGITS{BLANK_NIBBLE}};
      count_q     <= '0;
      neg_q       <= 1'b0;
      idx_q       <= '0;
      out_value_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_q      <= disp_d;
      count_q     <= count_d;
      neg_q       <= neg_d;
      idx_q       <= idx_d;
      out_value_q <= out_value_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  bcd_serial_to_bin #(
    .WIDTH (WIDTH)
  ) u_conv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (conv_start),
    .step_i   (conv_step),
    .digit_i  (digit),
    .neg_i    (neg_q),
    .result_o (conv_result),
    .ovf_o    (conv_ovf)
  );

  assign bcd_disp_o    = disp_q;
  assign digit_count_o = count_q;
  assign neg_o         = neg_q;
  assign busy_o        = (state_q != ST_ENTRY);
  assign out_valid_o   = (state_q == ST_HOLD);
  assign out_value_o   = out_value_q;
  assign out_ovf_o     = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry_unit
// Purpose  : Self-checking bench: table-driven edit-key vectors plus directed
//            conversion, saturation, handshake and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_unit;

  localparam int DIGITS = 11;
  localparam int WIDTH  = 32;
  localparam logic [43:0] BLANK = {11{4'hF}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        out_ready = 1'b0;
  logic [43:0] bcd_disp;
  logic [3:0]  digit_count;
  logic        neg, busy, out_valid, out_ovf;
  logic [31:0] out_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_entry_unit #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .key_valid_i   (key_valid),
    .key_code_i    (key_code),
    .out_ready_i   (out_ready),
    .bcd_disp_o    (bcd_disp),
    .digit_count_o (digit_count),
    .neg_o         (neg),
    .busy_o        (busy),
    .out_valid_o   (out_valid),
    .out_value_o   (out_value),
    .out_ovf_o     (out_ovf)
  );

  typedef struct {
    logic [3:0]  key;
    logic [43:0] disp;
    logic [3:0]  cnt;
    logic        neg;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk); key_valid = 1'b1; key_code = k;
    @(negedge clk); key_valid = 1'b0;
  endtask

  // Enter, then count edges after the enter edge until out_valid is seen.
  task automatic do_conv(input string nm, input int n, input logic [31:0] ev, input logic eo);
    int k;
    @(negedge clk); key_valid = 1'b1; key_code = 4'hD;
    @(posedge clk);
    @(negedge clk); key_valid = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, k, n + 1);
    chk({nm, "_value"}, out_value, ev);
    chk({nm, "_ovf"}, out_ovf, eo);
  endtask

  task automatic hs(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_hs_valid"}, out_valid, 0);
    chk({nm, "_hs_count"}, digit_count, 0);
    chk({nm, "_hs_disp"}, bcd_disp, BLANK);
    chk({nm, "_hs_neg"}, neg, 0);
    out_ready = 1'b0;
  endtask

  task automatic press_digits(input logic [3:0] d[], input int len);
    for (int i = 0; i < len; i++) press(d[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq[];

    tbl[0]  = '{4'h1, 44'hFFFFFFFFFF1, 4'd1, 1'b0};
    tbl[1]  = '{4'h2, 44'hFFFFFFFFF12, 4'd2, 1'b0};
    tbl[2]  = '{4'hA, 44'hFFFFFFFFF12, 4'd2, 1'b1};
    tbl[3]  = '{4'hB, 44'hFFFFFFFFFF1, 4'd1, 1'b1};
    tbl[4]  = '{4'hB, BLANK,           4'd0, 1'b1};
    tbl[5]  = '{4'hB, BLANK,           4'd0, 1'b1};
    tbl[6]  = '{4'hA, BLANK,           4'd0, 1'b0};
    tbl[7]  = '{4'hE, BLANK,           4'd0, 1'b0};
    tbl[8]  = '{4'h0, 44'hFFFFFFFFFF0, 4'd1, 1'b0};
    tbl[9]  = '{4'h7, 44'hFFFFFFFFF07, 4'd2, 1'b0};
    tbl[10] = '{4'hC, BLANK,           4'd0, 1'b0};
    tbl[11] = '{4'hA, BLANK,           4'd0, 1'b1};
    tbl[12] = '{4'hC, BLANK,           4'd0, 1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_disp", bcd_disp, BLANK);
    chk("rst_count", digit_count, 0);
    chk("rst_neg", neg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_ovf", out_ovf, 0);

    for (int i = 0; i < 13; i++) begin
      press(tbl[i].key);
      chk($sformatf("vec%0d_disp", i), bcd_disp, tbl[i].disp);
      chk($sformatf("vec%0d_count", i), digit_count, tbl[i].cnt);
      chk($sformatf("vec%0d_neg", i), neg, tbl[i].neg);
    end

    // 1,2,3 with out_ready already high
    out_ready = 1'b1;
    seq = '{4'h1, 4'h2, 4'h3};
    press_digits(seq, 3);
    chk("p123_disp", bcd_disp, 44'hFFFFFFFF123);
    do_conv("p123", 3, 32'd123, 1'b0);
    hs("p123");

    seq = '{4'h4, 4'h5, 4'hA};
    press_digits(seq, 3);
    do_conv("m45", 2, 32'hFFFFFFD3, 1'b0);
    hs("m45");

    press(4'hA); press(4'hA);
    chk("sign_twice", neg, 0);
    press(4'hC);

    seq = '{4'h2, 4'h1, 4'h4, 4'h7, 4'h4, 4'h8, 4'h3, 4'h6, 4'h4, 4'h8};
    press_digits(seq, 10);
    do_conv("pos_sat", 10, 32'h7FFFFFFF, 1'b1);
    hs("pos_sat");

    press_digits(seq, 10);
    press(4'hA);
    do_conv("neg_min", 10, 32'h80000000, 1'b0);
    hs("neg_min");

    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h0, 4'h1, 4'h2};
    press_digits(seq, 12);
    chk("d12_count", digit_count, 11);
    chk("d12_disp", bcd_disp, 44'h12345678901);
    do_conv("d12", 11, 32'h7FFFFFFF, 1'b1);
    hs("d12");

    press(4'hB);
    chk("bs_empty_count", digit_count, 0);
    chk("bs_empty_disp", bcd_disp, BLANK);

    seq = '{4'h9, 4'h8, 4'hB};
    press_digits(seq, 3);
    do_conv("bs98", 1, 32'd9, 1'b0);
    hs("bs98");

    // Reset in the middle of a conversion
    seq = '{4'h1, 4'h2, 4'h3, 4'h4};
    press_digits(seq, 4);
    @(negedge clk); key_valid = 1'b1; key_code = 4'hD;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
    chk("midconv_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_value", out_value, 0);
    chk("arst_ovf", out_ovf, 0);
    chk("arst_count", digit_count, 0);
    chk("arst_disp", bcd_disp, BLANK);
    @(negedge clk); rst_n = 1'b1;
    press(4'h6);
    do_conv("after_rst", 1, 32'd6, 1'b0);
    hs("after_rst");

    // HOLD stalls with out_ready low; keys dropped meanwhile
    press(4'h5);
    do_conv("hold", 1, 32'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); key_valid = 1'b1; key_code = 4'h7;
      chk($sformatf("hold%0d_valid", i), out_valid, 1);
      chk($sformatf("hold%0d_value", i), out_value, 32'd5);
    end
    @(negedge clk); key_valid = 1'b0;
    chk("hold_count", digit_count, 1);
    // Key strobe on the handshake edge is dropped
    @(negedge clk); out_ready = 1'b1; key_valid = 1'b1; key_code = 4'h3;
    @(posedge clk); #1;
    chk("hs_edge_valid", out_valid, 0);
    @(negedge clk); key_valid = 1'b0; out_ready = 1'b0;
    chk("hs_edge_key_dropped", digit_count, 0);
    press(4'h4);
    chk("post_hs_key", bcd_disp, 44'hFFFFFFFFFF4);
    press(4'hC);

    // Empty entry converts to zero in one step
    out_ready = 1'b1;
    do_conv("zero", 1, 32'd0, 1'b0);
    hs("zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
